// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
//   Shared constants for the instruction-memory loader: FSM state encoding,
//   frame geometry, and small state-decoding helpers used by the loader FSM.
//   The frame is LEN_LO, LEN_HI, then BYTES_PER_WORD bytes per word (LSB first),
//   optionally followed by one XOR checksum byte (LOADER_CHECKSUM_EN).
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_BYTES      = 2;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LEN_LO = 3'd1;
    localparam logic [2:0] ST_LEN_HI = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_CHK    = 3'd4;
    localparam logic [2:0] ST_FIN    = 3'd5;
    localparam logic [2:0] ST_ERR    = 3'd6;

    // States in which the loader takes a byte from the host link.
    function automatic logic st_accepts_byte(input logic [2:0] st);
        return (st == ST_LEN_LO) || (st == ST_LEN_HI) || (st == ST_DATA) || (st == ST_CHK);
    endfunction

    // States in which the CPU must be held off the instruction memory.
    function automatic logic st_holds_cpu(input logic [2:0] st);
        return st_accepts_byte(st) || (st == ST_FIN);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if
//   Bundles the host byte stream (in_valid/in_data/in_ready) and the
//   instruction-memory write port (im_we/im_a/im_d).
//   slave  : loader side (consumes bytes, drives the IM write port)
//   master : host/memory side (drives bytes, observes the write port)
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_a;
    logic [31:0]       im_d;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output im_we,
        output im_a,
        output im_d
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  im_we,
        input  im_a,
        input  im_d
    );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// byte_packer
//   Assembles little-endian 32-bit words from a byte stream. Byte k of a word
//   lands in bits [8k+7:8k]. When the 4th byte arrives the word register is
//   loaded and word_valid pulses for one cycle; word holds its value otherwise.
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   clr          restart at byte 0 (new frame); partial bytes discarded
//   byte_valid   byte_data is consumed this cycle
//   byte_data    incoming byte
//   word         last assembled word (0 after reset)
//   word_valid   1-cycle pulse, the cycle after the 4th byte
//   last_byte    the next consumed byte completes the word
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid,
    output logic        last_byte
);
    localparam int LANES = BYTES_PER_WORD - 1;

    logic [1:0]            idx_reg;
    logic [LANES-1:0][7:0] lane_reg;
    logic [LANES-1:0]      lane_en;
    logic [31:0]           word_reg;
    logic                  word_valid_reg;

    assign last_byte = (idx_reg == 2'(BYTES_PER_WORD - 1));

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane_en
            assign lane_en[gi] = byte_valid && (idx_reg == 2'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg        <= '0;
            lane_reg       <= '0;
            word_reg       <= '0;
            word_valid_reg <= 1'b0;
        end else begin
            word_valid_reg <= 1'b0;
            if (clr) begin
                idx_reg  <= '0;
                lane_reg <= '0;
            end else if (byte_valid) begin
                idx_reg <= idx_reg + 2'd1;
                for (int i = 0; i < LANES; i++) begin
                    if (lane_en[i]) lane_reg[i] <= byte_data;
                end
                if (last_byte) begin
                    word_reg       <= {byte_data, lane_reg[2], lane_reg[1], lane_reg[0]};
                    word_valid_reg <= 1'b1;
                end
            end
        end
    end

    assign word       = word_reg;
    assign word_valid = word_valid_reg;
endmodule

// File: rtl/imem_loader.sv
// imem_loader
//   Writer side of the instruction memory. Receives a framed byte stream,
//   assembles little-endian words and writes them sequentially from BASE_ADDR,
//   holding the CPU for the whole load.
//   Frame: LEN_LO, LEN_HI (word count N), 4*N data bytes, LSB first.
//   Optional feature macro: LOADER_CHECKSUM_EN -- a trailing byte equal to the
//   XOR of all preceding frame bytes is checked; mismatch raises err.
// Ports
//   clk, rst_n  clock, asynchronous active-low reset
//   start       1-cycle pulse, begins a frame (only honoured in IDLE)
//   bus         imem_loader_if.slave: in_valid/in_data/in_ready byte stream,
//               im_we/im_a/im_d instruction-memory write port
//   cpu_hold    CPU stall request during a load
//   done        1-cycle pulse on successful completion
//   err         sticky error flag, cleared by the next accepted start
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    imem_loader_if.slave bus,
    output logic         cpu_hold,
    output logic         done,
    output logic         err
);
    localparam int MAX_WORDS = (1 << ADDR_W) - BASE_ADDR;

    logic [2:0]        state_reg, state_next;
    logic              fin_wait_reg, fin_wait_next;
    logic [7:0]        len_lo_reg;
    logic [15:0]       len_reg;
    logic [ADDR_W:0]   word_cnt_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              err_reg;

    logic              xfer;
    logic              start_acc;
    logic              data_xfer;
    logic              last_data;
    logic [15:0]       len_full;
    logic [31:0]       words_after;
    logic [31:0]       pk_word;
    logic              pk_valid;
    logic              pk_last;

    assign bus.in_ready = st_accepts_byte(state_reg);
    assign cpu_hold     = st_holds_cpu(state_reg);
    // FIN entered from DATA waits one cycle so done follows the final write.
    assign done         = (state_reg == ST_FIN) && !fin_wait_reg;
    assign err          = err_reg;

    assign xfer        = bus.in_valid && bus.in_ready;
    assign start_acc   = start && (state_reg == ST_IDLE);
    assign data_xfer   = xfer && (state_reg == ST_DATA);
    assign len_full    = {bus.in_data, len_lo_reg};
    assign words_after = 32'(word_cnt_reg) + 32'd1;
    assign last_data   = data_xfer && pk_last && (words_after == {16'd0, len_reg});

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] chk_reg;
    logic       chk_ok;

    assign chk_ok = (bus.in_data == chk_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_reg <= '0;
        end else if (start_acc) begin
            chk_reg <= '0;
        end else if (xfer && (state_reg != ST_CHK)) begin
            chk_reg <= chk_reg ^ bus.in_data;
        end
    end
`endif

    always_comb begin
        state_next    = state_reg;
        fin_wait_next = fin_wait_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) state_next = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                if (xfer) state_next = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                if (xfer) begin
                    if (len_full == 16'd0) begin
                        state_next    = ST_FIN;
                        fin_wait_next = 1'b0;
                    end else if ({16'd0, len_full} > 32'(MAX_WORDS)) begin
                        state_next = ST_ERR;
                    end else begin
                        state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (last_data) begin
`ifdef LOADER_CHECKSUM_EN
                    state_next = ST_CHK;
`else
                    state_next    = ST_FIN;
                    fin_wait_next = 1'b1;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (xfer) begin
                    if (chk_ok) begin
                        state_next    = ST_FIN;
                        fin_wait_next = 1'b0;
                    end else begin
                        state_next = ST_ERR;
                    end
                end
            end
`endif
            ST_FIN: begin
                if (fin_wait_reg) fin_wait_next = 1'b0;
                else              state_next    = ST_IDLE;
            end
            ST_ERR:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            fin_wait_reg <= 1'b0;
            len_lo_reg   <= '0;
            len_reg      <= '0;
            word_cnt_reg <= '0;
            addr_reg     <= ADDR_W'(BASE_ADDR);
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            fin_wait_reg <= fin_wait_next;

            if (start_acc)                  err_reg <= 1'b0;
            else if (state_next == ST_ERR)  err_reg <= 1'b1;

            if (start_acc) word_cnt_reg <= '0;

            if (xfer && (state_reg == ST_LEN_LO)) len_lo_reg <= bus.in_data;
            if (xfer && (state_reg == ST_LEN_HI)) len_reg    <= len_full;

            // Address is latched with the 4th byte so it lines up with the
            // packer's word_valid pulse one cycle later.
            if (data_xfer && pk_last) begin
                addr_reg     <= ADDR_W'(BASE_ADDR) + word_cnt_reg[ADDR_W-1:0];
                word_cnt_reg <= word_cnt_reg + (ADDR_W + 1)'(1);
            end
        end
    end

    byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (start_acc),
        .byte_valid (data_xfer),
        .byte_data  (bus.in_data),
        .word       (pk_word),
        .word_valid (pk_valid),
        .last_byte  (pk_last)
    );

    assign bus.im_we = pk_valid;
    assign bus.im_a  = addr_reg;
    assign bus.im_d  = pk_word;
endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
    localparam int ADDR_W = 8;
    localparam int BASE   = 0;
    localparam int LIMIT  = (1 << ADDR_W) - BASE;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic cpu_hold, done, err;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int failed    = 0;
    int cyc       = 0;

    // Scoreboard queues: expected writes and expected end-of-frame events.
    // Event codes: 1 = done after data words, 2 = done with no words, 3 = err.
    logic [ADDR_W-1:0] exp_a_q[$];
    logic [31:0]       exp_d_q[$];
    int                exp_ev_q[$];
    logic [7:0]        frame_data[$];

    logic              prev_we = 1'b0, prev_done = 1'b0, prev_err = 1'b0;
    logic [ADDR_W-1:0] mon_a;
    logic [31:0]       mon_d;
    int                mon_ev;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT writes or ends a frame.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_we   = 1'b0;
            prev_done = 1'b0;
            prev_err  = 1'b0;
        end else begin
            if (bus.im_we) begin
                if (exp_a_q.size() == 0) begin
                    tests_run++;
                    failed++;
                    $display("FAIL unexpected_write: got a=%0d d=0x%08h required no write", bus.im_a, bus.im_d);
                end else begin
                    mon_a = exp_a_q.pop_front();
                    mon_d = exp_d_q.pop_front();
                    check("write_addr", 32'(bus.im_a), 32'(mon_a));
                    check("write_data", bus.im_d, mon_d);
                    $display("[TB] write a=%0d d=0x%08h (exp a=%0d d=0x%08h)", bus.im_a, bus.im_d, mon_a, mon_d);
                end
            end
            if (done || (err && !prev_err)) begin
                if (exp_ev_q.size() == 0) begin
                    tests_run++;
                    failed++;
                    $display("FAIL unexpected_end: got done=%0b err=%0b required none", done, err);
                end else begin
                    mon_ev = exp_ev_q.pop_front();
                    check("end_flags", {30'd0, err, done}, (mon_ev == 3) ? 32'd2 : 32'd1);
                    if (done) begin
                        check("done_single", {31'd0, prev_done}, 32'd0);
`ifndef LOADER_CHECKSUM_EN
                        check("done_after_we", {31'd0, prev_we}, (mon_ev == 1) ? 32'd1 : 32'd0);
`endif
                    end
                    $display("[TB] frame end done=%0b err=%0b (exp code %0d)", done, err, mon_ev);
                end
            end
            prev_we   = bus.im_we;
            prev_done = done;
            prev_err  = err;
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("hold_after_start", {31'd0, cpu_hold}, 32'd1);
        check("ready_len_lo", {31'd0, bus.in_ready}, 32'd1);
        check("err_cleared", {31'd0, err}, 32'd0);
    endtask

    // Called between negedge and posedge; returns at the negedge after transfer.
    task automatic send_byte(input logic [7:0] b, input bit gaps, input bit poke);
        int guard = 0;
        if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
                start        = poke && ($urandom_range(0, 3) == 0);
                @(negedge clk);
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        forever begin
            start = poke && ($urandom_range(0, 3) == 0);
            if (bus.in_ready) begin
                @(negedge clk);
                break;
            end
            guard++;
            if (guard > 50) begin
                check("byte_accept_timeout", {31'd0, bus.in_ready}, 32'd1);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_end(input int budget);
        int g = 0;
        while ((exp_ev_q.size() != 0 || exp_a_q.size() != 0) && g < budget) begin
            @(negedge clk);
            #1;
            g++;
        end
        check("frame_complete", 32'(exp_ev_q.size() + exp_a_q.size()), 32'd0);
        @(negedge clk);
        #1;
        check("ready_idle", {31'd0, bus.in_ready}, 32'd0);
        check("hold_idle", {31'd0, cpu_hold}, 32'd0);
    endtask

    // Reference model: expected writes/outcome come straight from the frame
    // rules, then the frame is driven onto the link.
    task automatic run_frame(input int n, input bit gaps, input bit poke, input bit bad_chk);
        logic [15:0] len16;
        logic [7:0]  x;
        logic [31:0] w;
        int          t0;
        bit          has_data;
        len16    = 16'(n);
        has_data = (n > 0) && (n <= LIMIT);
        if (n == 0) begin
            exp_ev_q.push_back(2);
        end else if (n > LIMIT) begin
            exp_ev_q.push_back(3);
        end else begin
            for (int i = 0; i < n; i++) begin
                w = 32'(frame_data[4*i]) | (32'(frame_data[4*i+1]) << 8)
                  | (32'(frame_data[4*i+2]) << 16) | (32'(frame_data[4*i+3]) << 24);
                exp_a_q.push_back(ADDR_W'(BASE + i));
                exp_d_q.push_back(w);
            end
`ifdef LOADER_CHECKSUM_EN
            exp_ev_q.push_back(bad_chk ? 3 : 1);
`else
            exp_ev_q.push_back(1);
`endif
        end
        pulse_start();
        x = len16[7:0] ^ len16[15:8];
        send_byte(len16[7:0], gaps, poke);
        send_byte(len16[15:8], gaps, poke);
        if (has_data) begin
            t0 = cyc;
            for (int i = 0; i < 4 * n; i++) begin
                send_byte(frame_data[i], gaps, poke);
                x = x ^ frame_data[i];
            end
            if (!gaps) check("full_rate", 32'(cyc - t0), 32'(4 * n));
`ifdef LOADER_CHECKSUM_EN
            send_byte(bad_chk ? (x ^ 8'h5a) : x, gaps, poke);
`endif
        end
        bus.in_valid = 1'b0;
        start        = 1'b0;
        wait_end(2000);
    endtask

    task automatic case1_data();
        frame_data = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    endtask

    task automatic rand_data(input int n);
        frame_data.delete();
        for (int i = 0; i < 4 * n; i++) frame_data.push_back(8'($urandom));
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        #12;
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("rst_im_we", {31'd0, bus.im_we}, 32'd0);
        check("rst_im_a", 32'(bus.im_a), 32'(BASE));
        check("rst_im_d", bus.im_d, 32'd0);
        check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Case 1: two-word program, back-to-back.
        case1_data();
        run_frame(2, 1'b0, 1'b0, 1'b0);

        // Zero-length frame.
        run_frame(0, 1'b0, 1'b0, 1'b0);

        // Oversize length (257 words); sticky err, cleared by next start.
        run_frame(257, 1'b0, 1'b0, 1'b0);
        check("err_sticky", {31'd0, err}, 32'd1);

        // Case 1 again with random gaps and stray start pulses mid-frame.
        case1_data();
        run_frame(2, 1'b1, 1'b1, 1'b0);

        // Full-depth frame: last write lands at the top address.
        rand_data(LIMIT);
        run_frame(LIMIT, 1'b0, 1'b0, 1'b0);

        // Random frames.
        for (int f = 0; f < 6; f++) begin
            int n;
            n = $urandom_range(1, 6);
            rand_data(n);
            run_frame(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

`ifdef LOADER_CHECKSUM_EN
        // Wrong checksum: words still written, err raised.
        case1_data();
        run_frame(2, 1'b0, 1'b0, 1'b1);
        check("chk_err", {31'd0, err}, 32'd1);
        case1_data();
        run_frame(2, 1'b1, 1'b0, 1'b0);
`endif

        // Reset after two words of a four-word frame.
        rand_data(4);
        for (int i = 0; i < 2; i++) begin
            exp_a_q.push_back(ADDR_W'(BASE + i));
            exp_d_q.push_back(32'(frame_data[4*i]) | (32'(frame_data[4*i+1]) << 8)
                            | (32'(frame_data[4*i+2]) << 16) | (32'(frame_data[4*i+3]) << 24));
        end
        pulse_start();
        send_byte(8'h04, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_byte(frame_data[i], 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        start = 1'b1;
        #1;
        check("mid_rst_im_we", {31'd0, bus.im_we}, 32'd0);
        check("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("mid_rst_hold", {31'd0, cpu_hold}, 32'd0);
        check("mid_rst_im_a", 32'(bus.im_a), 32'(BASE));
        check("mid_rst_im_d", bus.im_d, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in_data = 8'($urandom);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check("post_rst_idle", {31'd0, bus.in_ready}, 32'd0);
        check("post_rst_queue", 32'(exp_a_q.size() + exp_ev_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end
endmodule
